// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex display driver with once-per-frame input capture
module seg7_scan #(
  parameter int SCAN_DIV = 100_000,
  parameter int DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] DIV_LAST = W'(SCAN_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);
  logic [W-1:0] div_cnt;
  logic [2:0]   digit_idx;
  logic [31:0]  shadow_data, src_data;
  logic [7:0]   shadow_dp, shadow_blank, src_dp, src_blank, an_d;
  logic [3:0]   nib;
  logic [6:0]   seg_d;
  logic         load, div_wrap;
  // Frame start selects live inputs so digit 0 never shows stale shadow data
  always_comb begin
    div_wrap  = div_cnt == DIV_LAST;
    load      = div_cnt == '0 && digit_idx == 3'd0;
    src_data  = load ? data : shadow_data;
    src_dp    = load ? dp_mask : shadow_dp;
    src_blank = load ? blank_mask : shadow_blank;
    nib       = src_data[{digit_idx, 2'b00} +: 4];
    an_d      = src_blank[digit_idx] ? 8'hFF : ~(8'h01 << digit_idx);
  end
  // Active-low hex font, g..a
  always_comb begin
    case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end
  // Dwell counter and digit index, both wrapping only to legal values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) digit_idx <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
    end
  end
  // Capture inputs once per frame to avoid tearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else if (load) begin
      shadow_data  <= data;
      shadow_dp    <= dp_mask;
      shadow_blank <= blank_mask;
    end
  end
  // Registered display drive and frame-start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= ~src_dp[digit_idx];
      frame_done <= div_wrap && digit_idx == IDX_LAST;
    end
  end
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Seven-segment scan driver downstream of the board-input conversion stage. It consumes the 32-bit word chosen by display_op/ram_display_addr (muxed elsewhere) and time-multiplexes it as 8 hex digits on the board's common-anode display. It runs on the raw board clock, not the divided CPU clock, so the display stays live while the CPU is paused or single-stepping. Input data is captured once per frame to prevent tearing.

Parameters:
SCAN_DIV, 100_000, board-clock cycles each digit is lit (1 ms at 100 MHz); legal >= 2
DIGITS, 8, digits scanned per frame; legal 1..8; anodes for unused digits are held off

Ports:
clk  input  1  board clock
rst  input  1  asynchronous active-high reset
data  input  32  word to display; digit k shows data[4k+3:4k]
dp_mask  input  8  bit k=1 lights the decimal point of digit k
blank_mask  input  8  bit k=1 suppresses digit k (anode kept off)
an  output  8  anodes, active-low, an[k] = digit k
seg  output  7  segments a..g, active-low, seg[0]=a ... seg[6]=g
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when a new frame starts and inputs are captured

Behaviour:
- Reset (async, rst=1): div_cnt=0, digit_idx=0, shadow data/dp/blank=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0. Asserting rst mid-frame forces these values immediately. Scanning restarts from digit 0 on the first edge after release.
- div_cnt counts 0..SCAN_DIV-1 and wraps. At div_cnt==SCAN_DIV-1, digit_idx advances by 1 modulo DIGITS. div_cnt and digit_idx are only ever loaded with legal values.
- Load condition L = (div_cnt==0 && digit_idx==0). On each clock edge where L holds, shadow_data, shadow_dp and shadow_blank sample data, dp_mask and blank_mask.
- L is true on the first edge after reset release, so the first frame shows live data.
- Inputs are ignored at all other times. Changes mid-frame appear only from the next frame.
- frame_done is a registered output. It is 1 for exactly one cycle, the cycle after the edge where digit_idx wraps DIGITS-1 -> 0. That is the same cycle in which L is true for the new frame.
- frame_done is not asserted for the initial post-reset load.
- With DIGITS=1, frame_done pulses once every SCAN_DIV cycles.
- an, seg and dp are registered with 1-cycle latency from digit_idx. On the edge where L holds, the output register takes its nibble, dp and blank bit directly from the inputs (bypass), so digit 0 never shows stale shadow data.
- Output per slot k (k=digit_idx), with src = inputs on an L edge, otherwise the shadow registers:
  - an = all 1s except an[k]=0; if src blank bit k=1, an = 8'hFF
  - seg = hex decode of src nibble k
  - dp = ~src dp bit k
- Hex decode (active-low, g..a order): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Unused anodes an[7:DIGITS] are always 1.
- Exactly one anode is low at any time, unless the slot is blanked or rst is asserted.

Test Plan:
- Reset check (SCAN_DIV=4, DIGITS=8): assert rst mid-scan -> same cycle an=FF, seg=7F, dp=1, frame_done=0; after release, digit 0 lights on the first output update.
- Basic scan: data=32'h89ABCDEF, masks=0 -> an steps FE,FD,...,7F, each for exactly 4 cycles; seg sequence 0001110 (F), 0000110, 0100001, 1000110, 0000011, 0001000, 0010000, 0000000; frame period 32 cycles.
- Capture/tearing: change data from 32'h00000000 to 32'h11111111 during digit 3 of a frame -> rest of that frame shows 0 (1000000); next frame shows 1 (1111001) on every digit; frame_done high one cycle at each frame start.
- Masks: dp_mask=8'h05, blank_mask=8'h80 -> dp=0 only in slots 0 and 2; during slot 7, an=FF; other slots unaffected.
- DIGITS=4: an[7:4] stay 1; scan FE, FD, FB, F7; frame_done every 16 cycles (SCAN_DIV=4).
- Bypass at load edge: change data exactly in the cycle L holds -> first digit-0 output already reflects the new nibble, with no 1-cycle stale glitch.
